// File: rtl/pccard_pkg.sv
// pccard_pkg: shared definitions for the PC-card bus-cycle sequencer.
//   - Address-space encodings seen on host_space.
//   - Sequencer state type.
//   - Read-fill value for skipped or timed-out reads.
//   - Helpers for strobe selection, byte-lane steering and skipped cycles.
package pccard_pkg;

    localparam logic [1:0] SPC_ATTR   = 2'd0;
    localparam logic [1:0] SPC_COMMON = 2'd1;
    localparam logic [1:0] SPC_IO     = 2'd2;
    localparam logic [1:0] SPC_RSVD   = 2'd3;

    localparam logic [15:0] RD_FILL = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    // One-hot strobe vector ordered {oe, we, iord, iowr}.
    // Attribute space uses the memory strobes.
    function automatic logic [3:0] strobe_sel(input logic we, input logic [1:0] space);
        logic [3:0] s;
        case ({space == SPC_IO, we})
            2'b00:   s = 4'b1000;
            2'b01:   s = 4'b0100;
            2'b10:   s = 4'b0010;
            2'b11:   s = 4'b0001;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Attribute memory only decodes even bytes.
    // A high-byte-only access returns its byte in the low lane.
    function automatic logic [15:0] fmt_rdata(input logic [1:0] space, input logic [1:0] be,
                                              input logic [15:0] rd);
        logic [15:0] r;
        if (space == SPC_ATTR) begin
            r = {8'h00, rd[7:0]};
        end else if (be == 2'b10) begin
            r = {8'h00, rd[15:8]};
        end else begin
            r = rd;
        end
        return r;
    endfunction

    // Cycles with no enabled byte lane, or to the reserved space, never touch the card.
    function automatic logic is_skip(input logic [1:0] space, input logic [1:0] be);
        return (be == 2'b00) || (space == SPC_RSVD);
    endfunction

endpackage

// File: rtl/pccard_cycle_ctrl_if.sv
// pccard_cycle_ctrl_if: host-side request/ack bus of the PC-card cycle sequencer.
//   - host_req/host_we/host_space/host_addr/host_be/host_wdata: request from the host.
//   - host_rdata/host_ack/busy: completion back to the host.
// Modports:
//   - master: the host side.
//   - slave:  the sequencer side.
interface pccard_cycle_ctrl_if;
    logic        host_req;
    logic        host_we;
    logic [1:0]  host_space;
    logic [25:0] host_addr;
    logic [1:0]  host_be;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic        host_ack;
    logic        busy;

    modport master (
        output host_req, host_we, host_space, host_addr, host_be, host_wdata,
        input  host_rdata, host_ack, busy
    );

    modport slave (
        input  host_req, host_we, host_space, host_addr, host_be, host_wdata,
        output host_rdata, host_ack, busy
    );
endinterface

// File: rtl/pccard_sync2.sv
// pccard_sync2: two-flop synchroniser for asynchronous card level signals.
// Ports:
//   - clk, reset: clock and synchronous active-high reset.
//   - d: asynchronous input.
//   - q: synchronised output.
module pccard_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two-stage resynchronisation chain
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/pccard_cycle_ctrl.sv
// pccard_cycle_ctrl: bus-cycle sequencer between the host PCMCIA interface and the PC card.
// Sequence and timing:
//   - Accepts one request at a time.
//   - Drives address, CE and REG for SETUP_CYC clocks.
//   - Asserts one strobe for STROBE_CYC clocks; read data is sampled on the last strobe clock.
//   - Holds address/CE/REG for HOLD_CYC clocks.
//   - Pulses host_ack for one clock.
// Ports:
//   - clk, reset: clock and synchronous active-high reset.
//   - host: request/ack bus (pccard_cycle_ctrl_if.slave).
//   - cc_*: card address, data, REG, strobes and byte enables.
//   - cc_ireq/irq_clr/irq: card interrupt request, host clear and latched interrupt.
// Build option:
//   - PCCARD_WAIT_EN adds the cc_wait input.
//   - It stretches the strobe while the card holds WAIT, with a 16-bit timeout.
module pccard_cycle_ctrl
    import pccard_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        reset,
    pccard_cycle_ctrl_if.slave host,
    output logic [25:0] cc_addr,
    output logic [15:0] cc_wdata,
    input  logic [15:0] cc_rdata,
    output logic        cc_reg,
    output logic        cc_oe,
    output logic        cc_we,
    output logic        cc_iord,
    output logic        cc_iowr,
    output logic        cc_ce1,
    output logic        cc_ce2,
`ifdef PCCARD_WAIT_EN
    input  logic        cc_wait,
`endif
    input  logic        cc_ireq,
    input  logic        irq_clr,
    output logic        irq
);
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        we_r, we_s;
    logic [1:0]  space_r, space_s;
    logic [1:0]  be_r, be_s;
    logic [25:0] addr_r, addr_s;
    logic [15:0] wdata_r, wdata_s;
    logic [15:0] cap_r, cap_s;
    logic [15:0] rdata_r, rdata_s;
    logic        reg_r, reg_s;
    logic        ce1_r, ce1_s;
    logic        ce2_r, ce2_s;
    logic [3:0]  strb_r, strb_s;
    logic        ack_r, ack_s;
    logic        busy_r, busy_s;

`ifdef PCCARD_WAIT_EN
    logic        wait_sync_s;
    logic [15:0] tmo_r, tmo_s;

    pccard_sync2 u_sync_wait (
        .clk   (clk),
        .reset (reset),
        .d     (cc_wait),
        .q     (wait_sync_s)
    );
`endif

    // Next-state and next-output logic of the cycle sequencer
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        we_s    = we_r;
        space_s = space_r;
        be_s    = be_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        cap_s   = cap_r;
        rdata_s = rdata_r;
        reg_s   = reg_r;
        ce1_s   = ce1_r;
        ce2_s   = ce2_r;
        strb_s  = 4'b0000;
        ack_s   = 1'b0;
        busy_s  = busy_r;
`ifdef PCCARD_WAIT_EN
        tmo_s   = tmo_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (host.host_req) begin
                    we_s    = host.host_we;
                    space_s = host.host_space;
                    be_s    = host.host_be;
                    addr_s  = host.host_addr;
                    wdata_s = host.host_wdata;
                    busy_s  = 1'b1;
                    if (is_skip(host.host_space, host.host_be)) begin
                        // One idle HOLD clock with nothing enabled, so ack lands one cycle after acceptance
                        state_s = ST_HOLD;
                        cnt_s   = 4'd0;
                        cap_s   = RD_FILL;
                        reg_s   = 1'b0;
                        ce1_s   = 1'b0;
                        ce2_s   = 1'b0;
                    end else begin
                        state_s = ST_SETUP;
                        cnt_s   = SETUP_LD;
                        cap_s   = 16'h0000;
                        reg_s   = (host.host_space != SPC_COMMON);
                        ce1_s   = host.host_be[0];
                        ce2_s   = host.host_be[1];
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_STROBE;
                    cnt_s   = STROBE_LD;
                    strb_s  = strobe_sel(we_r, space_r);
`ifdef PCCARD_WAIT_EN
                    tmo_s   = 16'h0000;
`endif
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_STROBE: begin
                strb_s = strobe_sel(we_r, space_r);
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
`ifdef PCCARD_WAIT_EN
                    if (wait_sync_s && (tmo_r != 16'hFFFF)) begin
                        tmo_s = tmo_r + 16'd1;
                    end else begin
                        strb_s  = 4'b0000;
                        state_s = ST_HOLD;
                        cnt_s   = HOLD_LD;
                        if (wait_sync_s) begin
                            cap_s = RD_FILL;
                        end else if (!we_r) begin
                            cap_s = fmt_rdata(space_r, be_r, cc_rdata);
                        end else begin
                            cap_s = 16'h0000;
                        end
                    end
`else
                    strb_s  = 4'b0000;
                    state_s = ST_HOLD;
                    cnt_s   = HOLD_LD;
                    if (!we_r) begin
                        cap_s = fmt_rdata(space_r, be_r, cc_rdata);
                    end else begin
                        cap_s = 16'h0000;
                    end
`endif
                end
            end
            ST_HOLD: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_ACK;
                    ack_s   = 1'b1;
                    rdata_s = cap_r;
                    reg_s   = 1'b0;
                    ce1_s   = 1'b0;
                    ce2_s   = 1'b0;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                reg_s   = 1'b0;
                ce1_s   = 1'b0;
                ce2_s   = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered card/host outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            space_r <= 2'd0;
            be_r    <= 2'd0;
            addr_r  <= 26'd0;
            wdata_r <= 16'h0000;
            cap_r   <= 16'h0000;
            rdata_r <= 16'h0000;
            reg_r   <= 1'b0;
            ce1_r   <= 1'b0;
            ce2_r   <= 1'b0;
            strb_r  <= 4'b0000;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            we_r    <= we_s;
            space_r <= space_s;
            be_r    <= be_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            cap_r   <= cap_s;
            rdata_r <= rdata_s;
            reg_r   <= reg_s;
            ce1_r   <= ce1_s;
            ce2_r   <= ce2_s;
            strb_r  <= strb_s;
            ack_r   <= ack_s;
            busy_r  <= busy_s;
        end
    end

`ifdef PCCARD_WAIT_EN
    // WAIT-extension timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_r <= 16'h0000;
        end else begin
            tmo_r <= tmo_s;
        end
    end
`endif

    logic ireq_sync_s;
    logic ireq_d_r;
    logic irq_r;

    pccard_sync2 u_sync_ireq (
        .clk   (clk),
        .reset (reset),
        .d     (cc_ireq),
        .q     (ireq_sync_s)
    );

    // Interrupt latch: a rising edge of the synchronised request sets it and overrides a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ireq_d_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            ireq_d_r <= ireq_sync_s;
            if (ireq_sync_s && !ireq_d_r) begin
                irq_r <= 1'b1;
            end else if (irq_clr) begin
                irq_r <= 1'b0;
            end else begin
                irq_r <= irq_r;
            end
        end
    end

    assign cc_addr         = addr_r;
    assign cc_wdata        = wdata_r;
    assign cc_reg          = reg_r;
    assign cc_ce1          = ce1_r;
    assign cc_ce2          = ce2_r;
    assign cc_oe           = strb_r[3];
    assign cc_we           = strb_r[2];
    assign cc_iord         = strb_r[1];
    assign cc_iowr         = strb_r[0];
    assign host.host_rdata = rdata_r;
    assign host.host_ack   = ack_r;
    assign host.busy       = busy_r;
    assign irq             = irq_r;
endmodule

// File: tb/tb_pccard_cycle_ctrl.sv
// tb_pccard_cycle_ctrl: randomized self-checking bench for pccard_cycle_ctrl.
// Reference model:
//   - Expected per-cycle phase, strobe and byte-lane behaviour are derived from the cycle
//     timing rules (setup/strobe/hold/ack clock counts).
//   - Expected interrupt behaviour comes from a delayed-edge model of cc_ireq.
module tb_pccard_cycle_ctrl;
    localparam int S = 2;
    localparam int T = 4;
    localparam int H = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] cc_rdata;
    logic        cc_ireq;
    logic        irq_clr;
    logic [25:0] cc_addr;
    logic [15:0] cc_wdata;
    logic        cc_reg, cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2, irq;
`ifdef PCCARD_WAIT_EN
    logic        cc_wait;
`endif

    pccard_cycle_ctrl_if hif();

    pccard_cycle_ctrl #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
        .clk      (clk),
        .reset    (reset),
        .host     (hif),
        .cc_addr  (cc_addr),
        .cc_wdata (cc_wdata),
        .cc_rdata (cc_rdata),
        .cc_reg   (cc_reg),
        .cc_oe    (cc_oe),
        .cc_we    (cc_we),
        .cc_iord  (cc_iord),
        .cc_iowr  (cc_iowr),
        .cc_ce1   (cc_ce1),
        .cc_ce2   (cc_ce2),
`ifdef PCCARD_WAIT_EN
        .cc_wait  (cc_wait),
`endif
        .cc_ireq  (cc_ireq),
        .irq_clr  (irq_clr),
        .irq      (irq)
    );

    int   vec_cnt = 0;
    int   err_cnt = 0;
    // Interrupt model: p1/p2/p3 are cc_ireq as sampled 1/2/3 edges ago.
    logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0, irq_m = 1'b0;
    bit   rand_irq = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] ctl_vec();
        return {cc_oe, cc_we, cc_iord, cc_iowr, cc_ce2, cc_ce1, cc_reg, hif.host_ack, hif.busy};
    endfunction

    // Advance one clock edge, land on the following negedge, check irq, then re-randomize card inputs.
    task automatic step();
        logic nxt;
        if (reset) begin
            nxt = 1'b0;
            p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
        end else begin
            nxt = (p2 & ~p3) | (irq_m & ~irq_clr);
            p3 = p2; p2 = p1; p1 = cc_ireq;
        end
        @(posedge clk);
        @(negedge clk);
        irq_m = nxt;
        chk("irq", irq, irq_m);
        if (rand_irq) begin
            if ($urandom_range(0, 5) == 0) cc_ireq = ~cc_ireq;
            irq_clr = ($urandom_range(0, 7) == 0);
        end
        cc_rdata = 16'($urandom);
    endtask

    task automatic scramble_host();
        hif.host_we    = 1'($urandom);
        hif.host_space = 2'($urandom);
        hif.host_addr  = 26'($urandom);
        hif.host_be    = 2'($urandom);
        hif.host_wdata = 16'($urandom);
    endtask

    task automatic run_txn(input logic we, input logic [1:0] sp, input logic [25:0] ad,
                           input logic [1:0] be, input logic [15:0] wd);
        bit          skip, live, in_strb;
        int          ack_j;
        logic [3:0]  es;
        logic [15:0] cap, er;
        logic [8:0]  ctl_e;
        skip  = (be == 2'b00) || (sp == 2'd3);
        ack_j = skip ? 1 : S + T + H;
        es    = (sp == 2'd2) ? (we ? 4'b0001 : 4'b0010) : (we ? 4'b0100 : 4'b1000);
        cap   = 16'h0000;
        hif.host_req = 1'b1; hif.host_we = we; hif.host_space = sp;
        hif.host_addr = ad; hif.host_be = be; hif.host_wdata = wd;
        for (int j = 0; j <= ack_j; j++) begin
            step();
            live    = !skip && (j < ack_j);
            in_strb = !skip && (j >= S) && (j < S + T);
            ctl_e = {(in_strb ? es : 4'b0000), (live ? be[1] : 1'b0), (live ? be[0] : 1'b0),
                     (live ? (sp != 2'd1) : 1'b0), (j == ack_j), 1'b1};
            chk("ctl", ctl_vec(), ctl_e);
            chk("addr", cc_addr, ad);
            chk("wdata", cc_wdata, wd);
            if (in_strb && (j == S + T - 1)) cap = cc_rdata;
            if (j == ack_j) begin
                if (skip)                er = 16'hFFFF;
                else if (we)             er = 16'h0000;
                else if (sp == 2'd0)     er = cap & 16'h00FF;
                else if (be == 2'b10)    er = cap >> 8;
                else                     er = cap;
                chk("rdata", hif.host_rdata, er);
                hif.host_req = 1'b0;
            end else begin
                scramble_host();
            end
        end
        step();
        chk("idle", ctl_vec(), 9'd0);
    endtask

    initial begin
        reset = 1'b1;
        hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_space = 2'd0;
        hif.host_addr = 26'd0; hif.host_be = 2'd0; hif.host_wdata = 16'h0000;
        cc_rdata = 16'h0000; cc_ireq = 1'b0; irq_clr = 1'b0;
`ifdef PCCARD_WAIT_EN
        cc_wait = 1'b0;
`endif
        step(); step();
        chk("rst_ctl", ctl_vec(), 9'd0);
        chk("rst_addr", cc_addr, 26'd0);
        chk("rst_wdata", cc_wdata, 16'h0000);
        chk("rst_rdata", hif.host_rdata, 16'h0000);
        reset = 1'b0;
        step();

        // Directed cycles
        run_txn(1'b0, 2'd0, 26'h000002, 2'b01, 16'h0000);
        run_txn(1'b1, 2'd2, 26'h000300, 2'b11, 16'h55AA);
        run_txn(1'b0, 2'd1, 26'h001234, 2'b10, 16'h0000);
        run_txn(1'b0, 2'd1, 26'h000010, 2'b00, 16'h0000);
        run_txn(1'b1, 2'd3, 26'h000020, 2'b11, 16'h1234);

        // Randomized cycles with background interrupt activity
        rand_irq = 1'b1;
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom), 2'($urandom), 26'($urandom), 2'($urandom), 16'($urandom));
        end

        // Reset in the middle of a strobe
        hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_space = 2'd1;
        hif.host_addr = 26'h0ABCDE; hif.host_be = 2'b11; hif.host_wdata = 16'h0000;
        for (int j = 0; j < S + 2; j++) step();
        chk("pre_rst_oe", cc_oe, 1'b1);
        reset = 1'b1; hif.host_req = 1'b0;
        step();
        chk("mid_rst_ctl", ctl_vec(), 9'd0);
        chk("mid_rst_addr", cc_addr, 26'd0);
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("post_rst_ctl", ctl_vec(), 9'd0);
        end
        run_txn(1'b0, 2'd2, 26'h000301, 2'b01, 16'h0000);

        // Directed interrupt latency and set-over-clear
        rand_irq = 1'b0;
        cc_ireq = 1'b0; irq_clr = 1'b1;
        for (int j = 0; j < 4; j++) step();
        irq_clr = 1'b0; cc_ireq = 1'b1;
        step(); step();
        chk("irq_early", irq, 1'b0);
        step();
        chk("irq_lat3", irq, 1'b1);
        cc_ireq = 1'b0; irq_clr = 1'b1;
        for (int j = 0; j < 4; j++) step();
        chk("irq_clr", irq, 1'b0);
        irq_clr = 1'b0; cc_ireq = 1'b1;
        step(); step();
        irq_clr = 1'b1;
        step();
        chk("irq_set_wins", irq, 1'b1);
        irq_clr = 1'b0;
        step();

`ifdef PCCARD_WAIT_EN
        begin
            int          nst;
            bit          got_ack;
            logic [15:0] wcap;
            nst = 0; got_ack = 1'b0; wcap = 16'h0000;
            cc_wait = 1'b1;
            hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_space = 2'd1;
            hif.host_addr = 26'h000400; hif.host_be = 2'b11; hif.host_wdata = 16'h0000;
            for (int k = 0; k < 200 && !got_ack; k++) begin
                step();
                if (k == 10) cc_wait = 1'b0;
                if (cc_oe) begin
                    nst++;
                    wcap = cc_rdata;
                end
                if (hif.host_ack) begin
                    got_ack = 1'b1;
                    chk("wait_rdata", hif.host_rdata, wcap);
                    hif.host_req = 1'b0;
                end
            end
            chk("wait_ack_seen", got_ack, 1'b1);
            chk("wait_stretched", (nst > T), 1'b1);
            step();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
